int_to_float_encoder: RTL and testbench

Converts a 32-bit two's-complement fixed-point value into the team's 32-bit floating-point word: bit 0 sign, bits 1:6 biased exponent (bias 31), bits 7:31 25-bit fraction with hidden leading one. It is the producer side of the floating-point adder datapath, generating its A/B operands. It returns the same 4-bit status vector the adder produces. Normalization is iterative, one bit per cycle, unless the fast-normalize option is compiled in.

---
 rtl/int_to_float_encoder.sv | 112 +++++++++++
 tb/tb_int_to_float_encoder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/int_to_float_encoder.sv
// int_to_float_encoder: fixed-point to 32-bit float encoder; define FAST_NORM_EN for one-step normalization
module int_to_float_encoder #(
    parameter int FRAC_BITS = 0
) (
    input  logic        clock_100kHz,
    input  logic        reset,
    input  logic [0:31] data_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [0:31] data_out,
    output logic [0:3]  status_out,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, OUT} state_t;
    state_t state, state_nx;
    logic [31:0] din, mag;
    logic        sign, normalized, guard, sticky, round_up, carry;
    logic [5:0]  lz;
    logic [24:0] frac, frac_r;
    logic signed [9:0] e;
`ifdef FAST_NORM_EN
    logic       norm_done;
    logic [5:0] clz;
    // leading-zero count of mag; the highest set bit wins
    always_comb begin
        clz = 6'd0;
        for (int i = 0; i < 32; i++)
            if (mag[i]) clz = 6'(31 - i);
    end
    assign normalized = norm_done;
`else
    assign normalized = mag[31];
`endif
    assign in_ready  = state == IDLE && !reset;
    assign out_valid = state == OUT;
    assign frac      = mag[30:6];
    assign guard     = mag[5];
    assign sticky    = |mag[4:0];
    assign round_up  = guard & (sticky | frac[0]);
    assign {carry, frac_r} = {1'b0, frac} + 26'(round_up);
    assign e = 10'sd62 - 10'(lz) - 10'(FRAC_BITS) + 10'(carry);
    // state register
    always_ff @(posedge clock_100kHz)
        state <= reset ? IDLE : state_nx;
    // next-state: a zero magnitude leaves NORM straight for OUT
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? ABS : IDLE;
            ABS:     state_nx = NORM;
            NORM:    state_nx = mag == 32'd0 ? OUT : normalized ? ROUND : NORM;
            ROUND:   state_nx = OUT;
            OUT:     state_nx = out_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end
    // datapath: capture, magnitude, normalize, round and encode
    always_ff @(posedge clock_100kHz) begin
        if (reset) begin
            din        <= 32'd0;
            mag        <= 32'd0;
            sign       <= 1'b0;
            lz         <= 6'd0;
            data_out   <= 32'd0;
            status_out <= 4'b0000;
`ifdef FAST_NORM_EN
            norm_done  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) din <= data_in;
                ABS: begin
                    sign <= din[31];
                    mag  <= din[31] ? -din : din;
                    lz   <= 6'd0;
`ifdef FAST_NORM_EN
                    norm_done <= 1'b0;
`endif
                end
                NORM: begin
                    if (mag == 32'd0) begin
                        data_out   <= 32'd0;
                        status_out <= 4'b1000;
                    end else if (!normalized) begin
`ifdef FAST_NORM_EN
                        mag       <= mag << clz;
                        lz        <= clz;
                        norm_done <= 1'b1;
`else
                        mag <= mag << 1;
                        lz  <= lz + 6'd1;
`endif
                    end
                end
                ROUND: begin
                    if (e >= 63) begin
                        data_out   <= {sign, 6'b111111, 25'd0};
                        status_out <= 4'b0101;
                    end else if (e <= 0) begin
                        data_out   <= {sign, 6'd0, 25'd0};
                        status_out <= 4'b0011;
                    end else begin
                        data_out   <= {sign, e[5:0], frac_r};
                        status_out <= guard | sticky ? 4'b0001 : 4'b1000;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_int_to_float_encoder.sv
// tb_int_to_float_encoder: table-driven scoreboard bench over FRAC_BITS 0, -31 and 62
module tb_int_to_float_encoder;
    logic        clock_100kHz = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] din[3];
    logic        iv[3], ordy[3], ir[3], ov[3];
    logic [31:0] dout[3];
    logic [3:0]  st[3];
    int passed = 0, total = 0;

    typedef struct {int k; logic [31:0] d; logic [31:0] q; logic [3:0] s; int lat;} vec_t;
    typedef struct {logic [31:0] q; logic [3:0] s;} exp_t;
    exp_t sb[$];
    vec_t vecs[15];

    always #5 clock_100kHz = ~clock_100kHz;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        int_to_float_encoder #(.FRAC_BITS(g == 0 ? 0 : g == 1 ? -31 : 62)) dut (
            .clock_100kHz(clock_100kHz),
            .reset(reset),
            .data_in(din[g]),
            .in_valid(iv[g]),
            .in_ready(ir[g]),
            .data_out(dout[g]),
            .status_out(st[g]),
            .out_valid(ov[g]),
            .out_ready(ordy[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    task automatic start(input int k, input logic [31:0] d);
        @(negedge clock_100kHz);
        din[k] = d;
        iv[k] = 1'b1;
        check("in_ready before accept", 32'(ir[k]), 32'd1);
        @(posedge clock_100kHz);
        #1 iv[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, input int lat, input string name);
        int n = 0;
        while (!ov[k] && n < 200) begin
            @(posedge clock_100kHz);
            #1 n++;
        end
        check({name, " latency"}, 32'(n), 32'(lat));
    endtask

    task automatic run(input vec_t v, input string name);
        exp_t x;
        int lat = v.lat;
`ifdef FAST_NORM_EN
        if (lat != 2) lat = 4;
`endif
        start(v.k, v.d);
        sb.push_back('{v.q, v.s});
        wait_out(v.k, lat, name);
        x = sb.pop_front();
        check({name, " data_out"}, dout[v.k], x.q);
        check({name, " status"}, 32'(st[v.k]), 32'(x.s));
        @(posedge clock_100kHz);
        #1 check({name, " out_valid drop"}, 32'(ov[v.k]), 32'd0);
    endtask

    initial begin
        vecs = '{
            '{0, 32'h00000001, 32'h3E000000, 4'b1000, 34},
            '{0, 32'hFFFFFFFE, 32'hC0000000, 4'b1000, 33},
            '{0, 32'h00000000, 32'h00000000, 4'b1000, 2},
            '{0, 32'h7FFFFFFF, 32'h7C000000, 4'b0001, 4},
            '{0, 32'h80000000, 32'hFC000000, 4'b1000, 3},
            '{0, 32'hFFFFFFFF, 32'hBE000000, 4'b1000, 34},
            '{0, 32'h00000003, 32'h41000000, 4'b1000, 33},
            '{0, 32'h40000010, 32'h7A000000, 4'b0001, 4},
            '{0, 32'h40000030, 32'h7A000002, 4'b0001, 4},
            '{0, 32'h40000001, 32'h7A000000, 4'b0001, 4},
            '{1, 32'h00000002, 32'h7E000000, 4'b0101, 33},
            '{1, 32'h00000001, 32'h7C000000, 4'b1000, 34},
            '{2, 32'h40000000, 32'h00000000, 4'b0011, 4},
            '{2, 32'h80000000, 32'h80000000, 4'b0011, 3},
            '{2, 32'h00000000, 32'h00000000, 4'b1000, 2}
        };
        for (int k = 0; k < 3; k++) begin
            din[k] = 32'd0;
            iv[k] = 1'b0;
            ordy[k] = 1'b1;
        end
        repeat (3) @(posedge clock_100kHz);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset out_valid %0d", k), 32'(ov[k]), 32'd0);
            check($sformatf("reset data_out %0d", k), dout[k], 32'd0);
            check($sformatf("reset status %0d", k), 32'(st[k]), 32'd0);
            check($sformatf("reset in_ready %0d", k), 32'(ir[k]), 32'd0);
        end
        @(negedge clock_100kHz);
        reset = 1'b0;
        #1 check("in_ready after reset", 32'(ir[0]), 32'd1);
        for (int i = 0; i < 15; i++) run(vecs[i], $sformatf("vec%0d", i));
        ordy[0] = 1'b0;
        start(0, 32'h7FFFFFFF);
        wait_out(0, 4, "stall");
        repeat (5) begin
            @(posedge clock_100kHz);
            #1;
            check("stall out_valid", 32'(ov[0]), 32'd1);
            check("stall data_out", dout[0], 32'h7C000000);
            check("stall status", 32'(st[0]), 32'b0001);
            check("stall in_ready", 32'(ir[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        @(posedge clock_100kHz);
        #1;
        check("release out_valid", 32'(ov[0]), 32'd0);
        check("retain data_out", dout[0], 32'h7C000000);
        check("retain status", 32'(st[0]), 32'b0001);
        check("release in_ready", 32'(ir[0]), 32'd1);
        start(0, 32'h00000001);
        repeat (4) @(posedge clock_100kHz);
        #1 reset = 1'b1;
        @(posedge clock_100kHz);
        #1;
        check("abort out_valid", 32'(ov[0]), 32'd0);
        check("abort data_out", dout[0], 32'd0);
        check("abort status", 32'(st[0]), 32'd0);
        check("abort in_ready", 32'(ir[0]), 32'd0);
        @(negedge clock_100kHz);
        reset = 1'b0;
        run('{0, 32'h00000001, 32'h3E000000, 4'b1000, 34}, "post-abort");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
